// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Lane request / data-memory port bundle for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int CNT_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [31:0]       addr0;
    logic [31:0]       addr1;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       rdata0;
    logic [31:0]       rdata1;
    logic              stallM;
    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output mem_we, mem_addr, mem_wdata, rdata0, rdata1, stallM, conflict_cnt
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  mem_we, mem_addr, mem_wdata, rdata0, rdata1, stallM, conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-lane data-memory arbiter; serialises same-cycle accesses in
//            program order. Optional macro DMEM_ARB_STORE_FWD_EN forwards a
//            lane-0 store to a same-word lane-1 load without stalling.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int CNT_W = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_hold0;
    logic               r_we1;
    logic [31:0]        r_addr1;
    logic [31:0]        r_wdata1;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_fwd;
    logic               w_capture;
    logic               w_mem_we;
    logic [31:0]        w_mem_addr;
    logic [31:0]        w_mem_wdata;
    logic [31:0]        w_rdata0;
    logic [31:0]        w_rdata1;
    logic               w_stall;

`ifdef DMEM_ARB_STORE_FWD_EN
    assign w_fwd = bus.we0 & ~bus.we1 & (bus.addr0[31:2] == bus.addr1[31:2]);
`else
    assign w_fwd = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hold0  <= '0;
            r_we1    <= 1'b0;
            r_addr1  <= '0;
            r_wdata1 <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_hold0  <= bus.mem_rdata;
                r_we1    <= bus.we1;
                r_addr1  <= bus.addr1;
                r_wdata1 <= bus.wdata1;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Outputs are forced quiet during reset so no stray write reaches memory.
    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_rdata0    = '0;
        w_rdata1    = '0;
        w_stall     = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (bus.req0) begin
                        w_mem_we    = bus.we0;
                        w_mem_addr  = bus.addr0;
                        w_mem_wdata = bus.wdata0;
                        w_rdata0    = bus.mem_rdata;
                        if (bus.req1) begin
                            if (w_fwd) begin
                                w_rdata1 = bus.wdata0;
                            end else begin
                                w_stall   = 1'b1;
                                w_capture = 1'b1;
                                w_next    = SECOND;
                            end
                        end
                    end else if (bus.req1) begin
                        w_mem_we    = bus.we1;
                        w_mem_addr  = bus.addr1;
                        w_mem_wdata = bus.wdata1;
                        w_rdata1    = bus.mem_rdata;
                    end
                end
                SECOND: begin
                    w_mem_we    = r_we1;
                    w_mem_addr  = r_addr1;
                    w_mem_wdata = r_wdata1;
                    w_rdata0    = r_hold0;
                    w_rdata1    = bus.mem_rdata;
                    w_next      = IDLE;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;
    assign bus.rdata0       = w_rdata0;
    assign bus.rdata1       = w_rdata1;
    assign bus.stallM       = w_stall;
    assign bus.conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a word-addressed memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    logic mem_load;

    dmem_arbiter_if                bus ();
    dmem_arbiter_if #(.CNT_W(2))   bus2 ();

    dmem_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    dmem_arbiter #(.CNT_W(2)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    assign bus2.req0      = bus.req0;
    assign bus2.req1      = bus.req1;
    assign bus2.we0       = bus.we0;
    assign bus2.we1       = bus.we1;
    assign bus2.addr0     = bus.addr0;
    assign bus2.addr1     = bus.addr1;
    assign bus2.wdata0    = bus.wdata0;
    assign bus2.wdata1    = bus.wdata1;
    assign bus2.mem_rdata = 32'h0;

    logic [31:0] mem [0:63];

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
            mem[16] <= 32'h0000_1234;
            mem[4]  <= 32'd5;
            mem[5]  <= 32'd7;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        bus.req0   = r0;
        bus.req1   = r1;
        bus.we0    = w0;
        bus.we1    = w1;
        bus.addr0  = a0;
        bus.addr1  = a1;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        logic        e_we;
        logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    } vec_t;

    vec_t vt [9];
    int   exp_cnt;

    initial begin
        vt[0] = '{1'b0,1'b0,1'b0,1'b0, 32'h00,32'h00, 32'h0,32'h0,    1'b0, 32'h00, 32'h0,    32'h0,         32'h0};
        vt[1] = '{1'b1,1'b0,1'b0,1'b0, 32'h40,32'h00, 32'h0,32'h0,    1'b0, 32'h40, 32'h0,    32'h1234,      32'h0};
        vt[2] = '{1'b0,1'b1,1'b0,1'b0, 32'h00,32'h14, 32'h0,32'h0,    1'b0, 32'h14, 32'h0,    32'h0,         32'd7};
        vt[3] = '{1'b1,1'b0,1'b1,1'b0, 32'h80,32'h00, 32'hDEAD,32'h0, 1'b1, 32'h80, 32'hDEAD, 32'hA000_0020, 32'h0};
        vt[4] = '{1'b0,1'b1,1'b0,1'b0, 32'h00,32'h80, 32'h0,32'h0,    1'b0, 32'h80, 32'h0,    32'h0,         32'hDEAD};
        vt[5] = '{1'b0,1'b1,1'b0,1'b1, 32'h00,32'h84, 32'h0,32'hBEEF, 1'b1, 32'h84, 32'hBEEF, 32'h0,         32'hA000_0021};
        vt[6] = '{1'b1,1'b0,1'b0,1'b0, 32'h84,32'h00, 32'h0,32'h0,    1'b0, 32'h84, 32'h0,    32'hBEEF,      32'h0};
        vt[7] = '{1'b0,1'b0,1'b1,1'b0, 32'h88,32'h00, 32'h99,32'h0,   1'b0, 32'h00, 32'h0,    32'h0,         32'h0};
        vt[8] = '{1'b1,1'b0,1'b0,1'b1, 32'h10,32'h90, 32'h0,32'h77,   1'b0, 32'h10, 32'h0,    32'd5,         32'h0};

        // Reset with a conflicting store bundle on the inputs: all outputs must stay quiet.
        reset    = 1'b1;
        mem_load = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h40, 32'h5A, 32'h5B);
        @(negedge clk);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_stall",  {31'b0, bus.stallM}, 32'h0);
        chk("rst_rdata0", bus.rdata0, 32'h0);
        chk("rst_rdata1", bus.rdata1, 32'h0);
        chk("rst_cnt",    32'(bus.conflict_cnt), 32'h0);
        next_cycle();
        mem_load = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].r0, vt[i].r1, vt[i].w0, vt[i].w1, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_mem_we", i),    {31'b0, bus.mem_we}, {31'b0, vt[i].e_we});
            chk($sformatf("v%0d_mem_addr", i),  bus.mem_addr,  vt[i].e_addr);
            chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vt[i].e_wdata);
            chk($sformatf("v%0d_rdata0", i),    bus.rdata0,    vt[i].e_rd0);
            chk($sformatf("v%0d_rdata1", i),    bus.rdata1,    vt[i].e_rd1);
            chk($sformatf("v%0d_stall", i),     {31'b0, bus.stallM}, 32'h0);
            chk($sformatf("v%0d_cnt", i),       32'(bus.conflict_cnt), 32'h0);
            next_cycle();
        end

        // Load-load conflict.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h14, 32'h0, 32'h0);
        @(negedge clk);
        chk("ll_c1_stall", {31'b0, bus.stallM}, 32'h1);
        chk("ll_c1_addr",  bus.mem_addr, 32'h10);
        next_cycle();
        @(negedge clk);
        chk("ll_c2_stall",  {31'b0, bus.stallM}, 32'h0);
        chk("ll_c2_addr",   bus.mem_addr, 32'h14);
        chk("ll_c2_rdata0", bus.rdata0, 32'd5);
        chk("ll_c2_rdata1", bus.rdata1, 32'd7);
        chk("ll_cnt",       32'(bus.conflict_cnt), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("ll_back_idle_stall", {31'b0, bus.stallM}, 32'h0);
        next_cycle();

        // Store-store to the same word: lane 1 must land last.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h20, 32'hAA, 32'hBB);
        @(negedge clk);
        chk("ss_c1_we",    {31'b0, bus.mem_we}, 32'h1);
        chk("ss_c1_wdata", bus.mem_wdata, 32'hAA);
        chk("ss_c1_stall", {31'b0, bus.stallM}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("ss_c2_we",    {31'b0, bus.mem_we}, 32'h1);
        chk("ss_c2_addr",  bus.mem_addr, 32'h20);
        chk("ss_c2_wdata", bus.mem_wdata, 32'hBB);
        chk("ss_c2_stall", {31'b0, bus.stallM}, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("ss_mem_final", mem[8], 32'hBB);
        chk("ss_cnt",       32'(bus.conflict_cnt), 32'd2);
        exp_cnt = 2;
        next_cycle();

        // Lane-0 store followed by a same-word lane-1 load.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h30, 32'd4985, 32'h0);
        @(negedge clk);
        chk("sl_c1_we", {31'b0, bus.mem_we}, 32'h1);
`ifdef DMEM_ARB_STORE_FWD_EN
        chk("sl_stall",  {31'b0, bus.stallM}, 32'h0);
        chk("sl_rdata1", bus.rdata1, 32'd4985);
        chk("sl_cnt",    32'(bus.conflict_cnt), 32'(exp_cnt));
        next_cycle();
`else
        chk("sl_c1_stall", {31'b0, bus.stallM}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("sl_c2_stall",  {31'b0, bus.stallM}, 32'h0);
        chk("sl_c2_rdata1", bus.rdata1, 32'd4985);
        chk("sl_c2_rdata0", bus.rdata0, 32'hA000_000C);
        exp_cnt = exp_cnt + 1;
        chk("sl_cnt",       32'(bus.conflict_cnt), 32'(exp_cnt));
        next_cycle();
`endif
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h30, 32'h0, 32'h0);
        @(negedge clk);
        chk("sl_after_stall",  {31'b0, bus.stallM}, 32'h0);
        chk("sl_after_rdata1", bus.rdata1, 32'd4985);
        next_cycle();

        // Reset pulse while the lane-1 store is pending.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h50, 32'h50, 32'h11, 32'h22);
        @(negedge clk);
        chk("rs_c1_stall", {31'b0, bus.stallM}, 32'h1);
        next_cycle();
        chk("rs_second_we", {31'b0, bus.mem_we}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rs_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rs_stall",  {31'b0, bus.stallM}, 32'h0);
        chk("rs_cnt",    32'(bus.conflict_cnt), 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("rs_no_lane1_write", mem[20], 32'h11);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h50, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rs_idle_addr",   bus.mem_addr, 32'h50);
        chk("rs_idle_rdata0", bus.rdata0, 32'h11);
        chk("rs_idle_stall",  {31'b0, bus.stallM}, 32'h0);
        next_cycle();

        // Five back-to-back conflicts: the 2-bit counter must stick at 3.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h14, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("sat%0d_cnt2", k), 32'(bus2.conflict_cnt), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("sat%0d_cnt16", k), 32'(bus.conflict_cnt), 32'(k));
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
